moore_seq_detect: RTL and testbench
===================================

// Module: moore_seq_detect
// PURPOSE
// Parametrised Moore sequence detector for board switch inputs; next generation of the team's 2-symbol FSMs.
// Detects a configurable pattern of up to MAX_LEN symbols of SYM_W bits on sw_in.
// Advances only on ctrl_in step pulses; has restart and latch modes and a saturating match counter.
// Sits between switch/debounce logic and LED/7-seg display logic on the board top level.
// PARAMETERS
// SYM_W    2  width of one input symbol (sw_in)
// MAX_LEN  4  maximum pattern length in symbols (>=1)
// CNT_W    8  width of match counter
// ST_W = $clog2(MAX_LEN+1), derived localparam; not overridable
// PORTS
// clk          in   1              system clock; all logic on rising edge
// reset        in   1              synchronous, active-high reset; loads configuration
// ctrl_in      in   1              step enable; FSM and counter advance only when 1
// sw_in        in   SYM_W          current input symbol
// pat_in       in   MAX_LEN*SYM_W  pattern; symbol i at [i*SYM_W +: SYM_W]; symbol 0 is matched first
// len_in       in   ST_W           pattern length, sampled at reset
// mode_in      in   1              0 = restart after match, 1 = latch at match; sampled at reset
// state_in     in   ST_W           initial state, sampled at reset
// state        out  ST_W           current state = number of pattern symbols matched so far
// out          out  1              Moore output; 1 iff state == len_q
// match_count  out  CNT_W          number of counted matches, saturating
// count_sat    out  1              1 iff match_count == 2^CNT_W-1
// BEHAVIOUR
// - Reset (sync, priority over ctrl_in):
//   - pat_q <= pat_in; mode_q <= mode_in.
//   - len_q <= clamp(len_in, 1..MAX_LEN): 0 -> 1, >MAX_LEN -> MAX_LEN.
//   - state <= (state_in <= len_q) ? state_in : 0, compared against the clamped len_q.
//   - out <= (loaded state == len_q); match_count <= 0; count_sat <= 0.
// - Config regs change only on reset; pat_in/len_in/mode_in are ignored otherwise.
// - ctrl_in = 0: all registers hold, sw_in is ignored.
// - ctrl_in = 1, next-state function with s = state:
//   - s < len_q and sw_in == pat_q[s] -> s+1.
//   - s < len_q, mismatch, sw_in == pat_q[0] -> 1.
//   - s < len_q, otherwise -> 0.
//   - s == len_q, mode_q = 0 (restart) -> (sw_in == pat_q[0]) ? 1 : 0.
//   - s == len_q, mode_q = 1 (latch) -> stays len_q until next reset.
// - Fallback is single-level (pat_q[0] only). No full overlap/KMP; the bench must model it exactly this way.
// - out is registered: out <= (next == len_q), updated in the same edge as state. Zero extra latency vs state.
// - Counter increments on a step where next == len_q and (state != len_q or mode_q = 0).
//   - len_q = 1 in restart mode: consecutive pat_q[0] symbols each count.
//   - Latch mode counts only entry into len_q.
// - match_count saturates at 2^CNT_W-1 with no wrap; count_sat <= (new count == max), registered.
// - Reset mid-sequence discards partial progress; state_in takes effect on that same edge.
// TESTING (SYM_W=2, MAX_LEN=4, pat_in=8'h2D => pattern 1,3,2; len_in=3; state_in=0)
// - Restart: reset, mode 0, steps sw=1,3,2 -> state 1,2,3; out=1 after 3rd edge; count=1. Then step sw=1 -> state=1, out=0.
// - Mismatch fallback: steps 1,1,3,2 -> state 1,1,2,3; out=1 at 4th; count=1. Step 0 from state 2 -> state 0.
// - Hold: ctrl_in=0 for 5 cycles with sw toggling -> state, out, count unchanged.
// - Latch: mode 1, steps 1,3,2 then 0,1,3 -> state stays 3, out=1, count stays 1. Reset -> state 0, count 0.
// - Saturation: CNT_W=2, len_in=1, mode 0, 5 steps of sw=1 -> count 1,2,3,3,3; count_sat=1 from 3rd step.
// - Clamp/reset mid-op: at state 2, reset with state_in=2, len_in=7 -> len_q=4, state=2. Reset with len_in=0, state_in=2 -> len_q=1, state=0.

Source files
------------

// File: rtl/moore_seq_detect_if.sv
// Bundles the step, symbol, configuration and status signals of the Moore sequence detector.
// The board top level is the master; the detector is the slave.
interface moore_seq_detect_if #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int ST_W = $clog2(MAX_LEN + 1);

  logic                     ctrl_in;
  logic [SYM_W-1:0]         sw_in;
  logic [MAX_LEN*SYM_W-1:0] pat_in;
  logic [ST_W-1:0]          len_in;
  logic                     mode_in;
  logic [ST_W-1:0]          state_in;
  logic [ST_W-1:0]          state;
  logic                     out;
  logic [CNT_W-1:0]         match_count;
  logic                     count_sat;

  modport master (
    output ctrl_in, sw_in, pat_in, len_in, mode_in, state_in,
    input  state, out, match_count, count_sat
  );

  modport slave (
    input  ctrl_in, sw_in, pat_in, len_in, mode_in, state_in,
    output state, out, match_count, count_sat
  );
endinterface

// File: rtl/moore_seq_detect.sv
// Moore detector for a configurable switch-symbol pattern with restart/latch modes
// and a saturating match counter; configuration is captured only on reset.
module moore_seq_detect #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  moore_seq_detect_if.slave  bus
);
  localparam int ST_W = $clog2(MAX_LEN + 1);
  localparam int NSYM = 2 ** ST_W;
  localparam logic [ST_W-1:0]  MAX_ST  = ST_W'(MAX_LEN);
  localparam logic [ST_W-1:0]  ONE_ST  = ST_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {MODE_RESTART = 1'b0, MODE_LATCH = 1'b1} mode_e;

  logic [MAX_LEN*SYM_W-1:0] pat_q;
  logic [ST_W-1:0]          len_q;
  mode_e                    mode_q;
  logic [ST_W-1:0]          state_q, state_d;
  logic                     out_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sat_q;

  logic [ST_W-1:0]          len_clamp;
  logic [ST_W-1:0]          state_init;
  logic                     count_hit;
  logic [SYM_W-1:0]         pat_sym [NSYM];

  // Table padded to a power of two so any state value indexes it safely.
  genvar gi;
  generate
    for (gi = 0; gi < NSYM; gi++) begin : g_sym
      if (gi < MAX_LEN) begin : g_used
        assign pat_sym[gi] = pat_q[gi*SYM_W +: SYM_W];
      end else begin : g_pad
        assign pat_sym[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    len_clamp = bus.len_in;
    if (bus.len_in == '0)
      len_clamp = ONE_ST;
    else if (bus.len_in > MAX_ST)
      len_clamp = MAX_ST;
    state_init = (bus.state_in <= len_clamp) ? bus.state_in : '0;
  end

  // Fallback on mismatch only considers the first pattern symbol.
  always_comb begin
    state_d = state_q;
    if (bus.ctrl_in) begin
      if (state_q == len_q) begin
        if (mode_q == MODE_RESTART)
          state_d = (bus.sw_in == pat_sym[0]) ? ONE_ST : '0;
      end else if (bus.sw_in == pat_sym[state_q]) begin
        state_d = state_q + ONE_ST;
      end else if (bus.sw_in == pat_sym[0]) begin
        state_d = ONE_ST;
      end else begin
        state_d = '0;
      end
    end
  end

  always_comb begin
    count_hit = bus.ctrl_in && (state_d == len_q) &&
                ((state_q != len_q) || (mode_q == MODE_RESTART));
    cnt_d = cnt_q;
    if (count_hit && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= bus.pat_in;
      len_q   <= len_clamp;
      mode_q  <= mode_e'(bus.mode_in);
      state_q <= state_init;
      out_q   <= (state_init == len_clamp);
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else if (bus.ctrl_in) begin
      state_q <= state_d;
      out_q   <= (state_d == len_q);
      cnt_q   <= cnt_d;
      sat_q   <= (cnt_d == CNT_MAX);
    end
  end

  assign bus.state       = state_q;
  assign bus.out         = out_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;
endmodule

// File: tb/tb_moore_seq_detect.sv
// Drives two detectors (8-bit and 2-bit counters) with directed and random steps and
// checks them every cycle against an integer model of the detection rules.
module tb_moore_seq_detect;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       t_ctrl = 1'b0;
  logic [1:0] t_sw = '0;
  logic [7:0] t_pat = '0;
  logic [2:0] t_len = '0;
  logic       t_mode = 1'b0;
  logic [2:0] t_sin = '0;

  moore_seq_detect_if #(.SYM_W(2), .MAX_LEN(4), .CNT_W(8)) if_a ();
  moore_seq_detect_if #(.SYM_W(2), .MAX_LEN(4), .CNT_W(2)) if_b ();

  assign if_a.ctrl_in = t_ctrl;  assign if_b.ctrl_in = t_ctrl;
  assign if_a.sw_in = t_sw;      assign if_b.sw_in = t_sw;
  assign if_a.pat_in = t_pat;    assign if_b.pat_in = t_pat;
  assign if_a.len_in = t_len;    assign if_b.len_in = t_len;
  assign if_a.mode_in = t_mode;  assign if_b.mode_in = t_mode;
  assign if_a.state_in = t_sin;  assign if_b.state_in = t_sin;

  moore_seq_detect #(.SYM_W(2), .MAX_LEN(4), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  moore_seq_detect #(.SYM_W(2), .MAX_LEN(4), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers, unbounded match total clipped per counter width.
  int m_pat [4];
  int m_len, m_state, m_mode, m_total, m_prev;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_pat[i] = (int'(t_pat) >> (2 * i)) & 3;
      m_len = (t_len == 0) ? 1 : ((t_len > 4) ? 4 : int'(t_len));
      m_state = (int'(t_sin) <= m_len) ? int'(t_sin) : 0;
      m_mode = int'(t_mode);
      m_total = 0;
      m_valid = 1'b1;
    end else if (m_valid && t_ctrl) begin
      m_prev = m_state;
      if (m_state == m_len)
        m_state = (m_mode == 1) ? m_len : ((int'(t_sw) == m_pat[0]) ? 1 : 0);
      else if (int'(t_sw) == m_pat[m_state])
        m_state = m_state + 1;
      else
        m_state = (int'(t_sw) == m_pat[0]) ? 1 : 0;
      if (m_state == m_len && (m_prev != m_len || m_mode == 0))
        m_total = m_total + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("a.state", int'(if_a.state), m_state);
      check("a.out", int'(if_a.out), (m_state == m_len) ? 1 : 0);
      check("a.count", int'(if_a.match_count), (m_total > 255) ? 255 : m_total);
      check("a.sat", int'(if_a.count_sat), (m_total >= 255) ? 1 : 0);
      check("b.state", int'(if_b.state), m_state);
      check("b.out", int'(if_b.out), (m_state == m_len) ? 1 : 0);
      check("b.count", int'(if_b.match_count), (m_total > 3) ? 3 : m_total);
      check("b.sat", int'(if_b.count_sat), (m_total >= 3) ? 1 : 0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [2:0] len, input logic mode, input logic [2:0] sin);
    reset = 1'b1; t_ctrl = 1'b0; t_pat = 8'h2D; t_len = len; t_mode = mode; t_sin = sin;
    cycle();
    reset = 1'b0;
    $display("reset len=%0d mode=%0d state_in=%0d -> state=%0d out=%0d", len, mode, sin, if_a.state, if_a.out);
  endtask

  task automatic step(input logic [1:0] sw);
    t_ctrl = 1'b1; t_sw = sw;
    cycle();
    t_ctrl = 1'b0;
    $display("step sw=%0d -> state=%0d out=%0d count=%0d/%0d sat_b=%0d",
             sw, if_a.state, if_a.out, if_a.match_count, if_b.match_count, if_b.count_sat);
  endtask

  initial begin
    // Restart mode, pattern 1,3,2
    do_reset(3'd3, 1'b0, 3'd0);
    check("lit.reset_state", int'(if_a.state), 0);
    check("lit.reset_count", int'(if_a.match_count), 0);
    step(2'd1); check("lit.r1", int'(if_a.state), 1);
    step(2'd3); check("lit.r2", int'(if_a.state), 2);
    step(2'd2); check("lit.r3", int'(if_a.state), 3);
    check("lit.r3_out", int'(if_a.out), 1);
    check("lit.r3_cnt", int'(if_a.match_count), 1);
    step(2'd1); check("lit.r4", int'(if_a.state), 1);
    check("lit.r4_out", int'(if_a.out), 0);

    // Single-level mismatch fallback
    do_reset(3'd3, 1'b0, 3'd0);
    step(2'd1); step(2'd1); check("lit.f2", int'(if_a.state), 1);
    step(2'd3); step(2'd2); check("lit.f4", int'(if_a.state), 3);
    check("lit.f4_cnt", int'(if_a.match_count), 1);
    step(2'd1); step(2'd3); step(2'd0); check("lit.f_zero", int'(if_a.state), 0);

    // Hold with a symbol that would otherwise advance
    step(2'd1); step(2'd3);
    for (int i = 0; i < 5; i++) begin
      t_sw = (i % 2 == 0) ? 2'd2 : 2'd1;
      cycle();
      $display("hold sw=%0d -> state=%0d", t_sw, if_a.state);
    end
    check("lit.hold_state", int'(if_a.state), 2);
    check("lit.hold_cnt", int'(if_a.match_count), 1);

    // Latch mode
    do_reset(3'd3, 1'b1, 3'd0);
    step(2'd1); step(2'd3); step(2'd2);
    step(2'd0); step(2'd1); step(2'd3);
    check("lit.latch_state", int'(if_a.state), 3);
    check("lit.latch_out", int'(if_a.out), 1);
    check("lit.latch_cnt", int'(if_a.match_count), 1);
    do_reset(3'd3, 1'b1, 3'd0);
    check("lit.latch_rst", int'(if_a.state), 0);

    // Saturation of the 2-bit counter
    do_reset(3'd1, 1'b0, 3'd0);
    for (int i = 1; i <= 5; i++) begin
      step(2'd1);
      check("lit.sat_cnt", int'(if_b.match_count), (i > 3) ? 3 : i);
      check("lit.sat_flag", int'(if_b.count_sat), (i >= 3) ? 1 : 0);
    end
    check("lit.sat_a", int'(if_a.match_count), 5);

    // Clamping and reset mid-sequence
    do_reset(3'd3, 1'b0, 3'd0);
    step(2'd1); step(2'd3);
    do_reset(3'd7, 1'b0, 3'd2);
    check("lit.clamp_state", int'(if_a.state), 2);
    check("lit.clamp_out", int'(if_a.out), 0);
    step(2'd2); step(2'd0);
    check("lit.clamp_len4", int'(if_a.state), 4);
    do_reset(3'd0, 1'b0, 3'd2);
    check("lit.len0_state", int'(if_a.state), 0);
    step(2'd1);
    check("lit.len0_out", int'(if_a.out), 1);
    do_reset(3'd3, 1'b0, 3'd3);
    check("lit.init_out", int'(if_a.out), 1);

    // Random steps with occasional random reconfiguration
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        t_pat = 8'($urandom); t_len = 3'($urandom); t_mode = 1'($urandom); t_sin = 3'($urandom);
      end else begin
        reset = 1'b0;
      end
      t_ctrl = ($urandom_range(0, 3) != 0);
      t_sw = 2'($urandom);
      cycle();
    end
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
